dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between the two issue lanes of the dual-issue MEM stage.
- Sits between the EX/MEM pipeline register outputs and the data memory.
- When both lanes present a memory operation in the same cycle, it serializes them in program order (lane 1 then lane 2) and raises a pipeline stall for one cycle.
- Merges both lanes' load data so the MEM/WB register captures both results together.

Parameters:
- DW, 8, data and address width.
- CNT_W, 16, width of the conflict-stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- memread_1  input  1  lane 1 load request (from EX/MEM).
- memwrite_1  input  1  lane 1 store request.
- addr_1  input  DW  lane 1 address (lane 1 ALU result).
- wdata_1  input  DW  lane 1 store data.
- memread_2  input  1  lane 2 load request.
- memwrite_2  input  1  lane 2 store request.
- addr_2  input  DW  lane 2 address.
- wdata_2  input  DW  lane 2 store data.
- mem_rdata  input  DW  data memory read data (asynchronous read of mem_addr).
- mem_addr  output  DW  data memory address.
- mem_wdata  output  DW  data memory write data.
- mem_re  output  1  data memory read enable.
- mem_we  output  1  data memory write enable (memory writes on the rising edge).
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- mem_done  output  1  both lanes' memory work for the current EX/MEM contents is complete; MEM/WB captures only when high.
- rdata_1  output  DW  lane 1 load data.
- rdata_2  output  DW  lane 2 load data.
- conflict_cnt  output  CNT_W  number of conflict stalls since reset.

Behaviour:
- Request decode: reqN = memread_N | memwrite_N. If both memread_N and memwrite_N are set, the op is treated as a store: mem_we=1, mem_re=0, rdata_N=0.
- State machine: states IDLE and SECOND. State register and hold1 register are updated synchronously.
- IDLE, req1 only:
  - Drive lane 1 onto the memory port.
  - stall=0, mem_done=1.
  - rdata_1 = mem_rdata if lane 1 is a load, else 0; rdata_2 = 0.
  - Stay in IDLE.
- IDLE, req2 only: same as above with lane 2; rdata_1 = 0. Stay in IDLE.
- IDLE, neither request: mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, mem_done=1, rdata_1=rdata_2=0.
- IDLE, req1 and req2 (conflict):
  - Drive lane 1 onto the port.
  - stall=1, mem_done=0.
  - hold1 <= (lane 1 load ? mem_rdata : 0).
  - conflict_cnt increments; it saturates at all-ones.
  - Next state SECOND.
- SECOND:
  - EX/MEM is unchanged because it was frozen. Lane 1 is NOT re-issued.
  - Drive lane 2 onto the port.
  - stall=0, mem_done=1.
  - rdata_1 = hold1; rdata_2 = (lane 2 load ? mem_rdata : 0).
  - Next state IDLE, unconditionally.
- Ordering: lane 1 completes before lane 2 starts.
  - Lane 1 store then lane 2 load to the same address: lane 2 sees the new data.
  - Both lanes store to the same address: lane 2 value persists.
- Latency: a single access completes in 1 cycle; a conflict takes 2 cycles, with exactly one stall cycle.
- Outputs are combinational from the state and the inputs, except hold1, conflict_cnt and the state register.
- Reset (sync, active-high):
  - On the edge: state<=IDLE, hold1<=0, conflict_cnt<=0.
  - During any cycle with reset high: mem_re=mem_we=0, stall=0, mem_done=0, rdata_1=rdata_2=0, mem_addr=mem_wdata=0.
  - Reset in SECOND abandons lane 2; no write is issued.
- Reset values of all outputs: 0.

Test Plan:
- Lane 1 store only, addr_1=0x10, wdata_1=0xA5 -> same cycle mem_we=1, mem_addr=0x10, mem_wdata=0xA5, stall=0, mem_done=1; conflict_cnt stays 0.
- Lane 2 load only, addr_2=0x10, mem holds 0xA5 -> mem_re=1, mem_addr=0x10, rdata_2=0xA5, rdata_1=0, stall=0.
- Both loads, addr_1=0x20 (mem 0x11), addr_2=0x21 (mem 0x22):
  - Cycle 1: mem_addr=0x20, stall=1, mem_done=0.
  - Cycle 2: mem_addr=0x21, stall=0, mem_done=1, rdata_1=0x11, rdata_2=0x22.
  - conflict_cnt=1.
- Lane 1 store 0x30<-0x5A, lane 2 load 0x30 -> cycle 1 write, cycle 2 read returns rdata_2=0x5A; both lanes store to 0x31 (0x01 then 0x02) -> mem[0x31]=0x02.
- Reset asserted in SECOND -> that cycle mem_we=mem_re=0, stall=0; next cycle state IDLE, conflict_cnt=0, hold1=0.
- Lane 1 with memread_1=memwrite_1=1 -> treated as store: mem_we=1, mem_re=0, rdata_1=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Lets the two issue lanes of the dual-issue MEM stage share one
//   single-ported data memory. If both lanes need the memory in the same
//   cycle, lane 1 goes first and the pipeline stalls for one cycle. Lane 2
//   goes in the next cycle. Lane 1 load data is held so that MEM/WB can
//   capture both results together.
//
// Ports
//   clk, reset                      clock (rising edge), sync active-high reset
//   memread_N/memwrite_N/addr_N/wdata_N   lane N request from EX/MEM (N=1,2)
//   mem_rdata                       async read data for mem_addr
//   mem_addr/mem_wdata/mem_re/mem_we      data memory port
//   stall                           freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_done                        MEM/WB may capture this cycle
//   rdata_1/rdata_2                 per-lane load data (0 for non-loads)
//   conflict_cnt                    saturating count of conflict stalls
//
// state  | meaning
// IDLE   | serve whichever lane requests; on conflict issue lane 1 and stall
// SECOND | issue lane 2 of a conflicting pair, lane 1 data comes from hold1
module dmem_port_arbiter #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_1,
  input  logic             memwrite_1,
  input  logic [DW-1:0]    addr_1,
  input  logic [DW-1:0]    wdata_1,
  input  logic             memread_2,
  input  logic             memwrite_2,
  input  logic [DW-1:0]    addr_2,
  input  logic [DW-1:0]    wdata_2,
  input  logic [DW-1:0]    mem_rdata,
  output logic [DW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic             stall,
  output logic             mem_done,
  output logic [DW-1:0]    rdata_1,
  output logic [DW-1:0]    rdata_2,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] hold1;
  logic          req1, req2, ld1, ld2, conflict;

  // A request with both read and write set counts as a store.
  assign req1     = memread_1 | memwrite_1;
  assign req2     = memread_2 | memwrite_2;
  assign ld1      = memread_1 & ~memwrite_1;
  assign ld2      = memread_2 & ~memwrite_2;
  assign conflict = (state == IDLE) && req1 && req2;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold1        <= '0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      hold1 <= ld1 ? mem_rdata : '0;
      if (conflict_cnt != {CNT_W{1'b1}})
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (conflict) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    stall     = 1'b0;
    mem_done  = 1'b0;
    rdata_1   = '0;
    rdata_2   = '0;
    if (!reset) begin
      mem_done = 1'b1;
      case (state)
        IDLE: begin
          if (req1) begin
            // Lane 1 always goes first, whether or not lane 2 conflicts.
            mem_addr  = addr_1;
            mem_wdata = wdata_1;
            mem_re    = ld1;
            mem_we    = memwrite_1;
            if (req2) begin
              stall    = 1'b1;
              mem_done = 1'b0;
            end else begin
              rdata_1 = ld1 ? mem_rdata : '0;
            end
          end else if (req2) begin
            mem_addr  = addr_2;
            mem_wdata = wdata_2;
            mem_re    = ld2;
            mem_we    = memwrite_2;
            rdata_2   = ld2 ? mem_rdata : '0;
          end
        end
        SECOND: begin
          mem_addr  = addr_2;
          mem_wdata = wdata_2;
          mem_re    = ld2;
          mem_we    = memwrite_2;
          rdata_1   = hold1;
          rdata_2   = ld2 ? mem_rdata : '0;
        end
        default: mem_done = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int DW = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic memread_1, memwrite_1, memread_2, memwrite_2;
  logic [DW-1:0] addr_1, wdata_1, addr_2, wdata_2;
  logic [DW-1:0] mem_rdata, mem_addr, mem_wdata, rdata_1, rdata_2;
  logic mem_re, mem_we, stall, mem_done;
  logic [CNT_W-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_port_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .memread_1(memread_1), .memwrite_1(memwrite_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .memread_2(memread_2), .memwrite_2(memwrite_2), .addr_2(addr_2), .wdata_2(wdata_2),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .stall(stall), .mem_done(mem_done),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .conflict_cnt(conflict_cnt)
  );

  // Apply lane inputs at the falling edge and let them settle before checks.
  task automatic drive(input logic r1, input logic w1, input logic [DW-1:0] a1,
                       input logic [DW-1:0] d1, input logic r2, input logic w2,
                       input logic [DW-1:0] a2, input logic [DW-1:0] d2);
    @(negedge clk);
    memread_1 = r1; memwrite_1 = w1; addr_1 = a1; wdata_1 = d1;
    memread_2 = r2; memwrite_2 = w2; addr_2 = a2; wdata_2 = d2;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h10, 8'h00, 1, 1, 8'h11, 8'h22);
    if ({mem_re, mem_we, stall, mem_done} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_ctrl got %b want 0000", {mem_re, mem_we, stall, mem_done});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, rdata_1, rdata_2} !== 32'h0) begin
      n_bad++; $display("FAIL rst_data got %h want 0", {mem_addr, mem_wdata, rdata_1, rdata_2});
    end
    n_cmp++;
    if (conflict_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rst_cnt got %0d want 0", conflict_cnt);
    end
    n_cmp++;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    #1;
    if ({mem_re, mem_we, stall, mem_done, mem_addr} !== {4'b0001, 8'h00}) begin
      n_bad++; $display("FAIL idle_none got %b/%h want 0001/00", {mem_re, mem_we, stall, mem_done}, mem_addr);
    end
    n_cmp++;
  endtask

  task automatic test_single_store();
    drive(0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    if ({mem_we, mem_re, stall, mem_done} !== 4'b1001) begin
      n_bad++; $display("FAIL st1_ctrl got %b want 1001", {mem_we, mem_re, stall, mem_done});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 16'h10A5) begin
      n_bad++; $display("FAIL st1_port got %h want 10a5", {mem_addr, mem_wdata});
    end
    n_cmp++;
    @(posedge clk); #1;
    if (conflict_cnt !== 16'd0) begin
      n_bad++; $display("FAIL st1_cnt got %0d want 0", conflict_cnt);
    end
    n_cmp++;
  endtask

  task automatic test_single_load2();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    if ({mem_re, mem_we, stall, mem_done, mem_addr} !== {4'b1001, 8'h10}) begin
      n_bad++; $display("FAIL ld2_ctrl got %b/%h want 1001/10", {mem_re, mem_we, stall, mem_done}, mem_addr);
    end
    n_cmp++;
    if ({rdata_1, rdata_2} !== 16'h00A5) begin
      n_bad++; $display("FAIL ld2_data got %h want 00a5", {rdata_1, rdata_2});
    end
    n_cmp++;
  endtask

  task automatic test_conflict_loads();
    drive(0, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00);
    drive(0, 0, 8'h00, 8'h00, 0, 1, 8'h21, 8'h22);
    drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00);
    if ({mem_addr, stall, mem_done, mem_re} !== {8'h20, 3'b101}) begin
      n_bad++; $display("FAIL cf_c1 got %h/%b want 20/101", mem_addr, {stall, mem_done, mem_re});
    end
    n_cmp++;
    @(negedge clk); #1;
    if ({mem_addr, stall, mem_done, mem_re} !== {8'h21, 3'b011}) begin
      n_bad++; $display("FAIL cf_c2 got %h/%b want 21/011", mem_addr, {stall, mem_done, mem_re});
    end
    n_cmp++;
    if ({rdata_1, rdata_2} !== 16'h1122) begin
      n_bad++; $display("FAIL cf_data got %h want 1122", {rdata_1, rdata_2});
    end
    n_cmp++;
    if (conflict_cnt !== 16'd1) begin
      n_bad++; $display("FAIL cf_cnt got %0d want 1", conflict_cnt);
    end
    n_cmp++;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    if ({stall, mem_done} !== 2'b01) begin
      n_bad++; $display("FAIL cf_back_idle got %b want 01", {stall, mem_done});
    end
    n_cmp++;
  endtask

  // Store-then-load and store-store pairs issued back to back.
  task automatic test_ordering();
    drive(0, 1, 8'h30, 8'h5A, 1, 0, 8'h30, 8'h00);
    if ({mem_we, mem_re, stall, mem_addr} !== {3'b101, 8'h30}) begin
      n_bad++; $display("FAIL ord_c1 got %b/%h want 101/30", {mem_we, mem_re, stall}, mem_addr);
    end
    n_cmp++;
    @(negedge clk); #1;
    if ({mem_we, mem_re, rdata_1, rdata_2} !== {2'b01, 8'h00, 8'h5A}) begin
      n_bad++; $display("FAIL ord_raw got %b/%h want 01/005a", {mem_we, mem_re}, {rdata_1, rdata_2});
    end
    n_cmp++;
    drive(0, 1, 8'h31, 8'h01, 0, 1, 8'h31, 8'h02);
    if ({stall, mem_wdata} !== {1'b1, 8'h01}) begin
      n_bad++; $display("FAIL ord_ww1 got %b/%h want 1/01", stall, mem_wdata);
    end
    n_cmp++;
    @(negedge clk); #1;
    if ({stall, mem_done, mem_wdata} !== {2'b01, 8'h02}) begin
      n_bad++; $display("FAIL ord_ww2 got %b/%h want 01/02", {stall, mem_done}, mem_wdata);
    end
    n_cmp++;
    drive(1, 0, 8'h31, 8'h00, 0, 0, 8'h00, 8'h00);
    if (rdata_1 !== 8'h02) begin
      n_bad++; $display("FAIL ord_waw got %h want 02", rdata_1);
    end
    n_cmp++;
    if (conflict_cnt !== 16'd3) begin
      n_bad++; $display("FAIL ord_cnt got %0d want 3", conflict_cnt);
    end
    n_cmp++;
  endtask

  task automatic test_reset_in_second();
    drive(0, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00);
    drive(1, 0, 8'h20, 8'h00, 0, 1, 8'h40, 8'hEE);
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL rs_c1 got %b want 1", stall);
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if ({mem_we, mem_re, stall, mem_done} !== 4'b0000) begin
      n_bad++; $display("FAIL rs_second got %b want 0000", {mem_we, mem_re, stall, mem_done});
    end
    n_cmp++;
    drive(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    #1;
    if ({stall, mem_done, mem_addr, rdata_1} !== {2'b01, 8'h40, 8'h77}) begin
      n_bad++; $display("FAIL rs_idle got %b/%h/%h want 01/40/77", {stall, mem_done}, mem_addr, rdata_1);
    end
    n_cmp++;
    if (conflict_cnt !== 16'd0) begin
      n_bad++; $display("FAIL rs_cnt got %0d want 0", conflict_cnt);
    end
    n_cmp++;
    // A conflict with a lane 1 store must expose hold1 as 0 in SECOND.
    drive(0, 1, 8'h50, 8'h99, 1, 0, 8'h20, 8'h00);
    @(negedge clk); #1;
    if ({rdata_1, rdata_2} !== 16'h0011) begin
      n_bad++; $display("FAIL rs_hold got %h want 0011", {rdata_1, rdata_2});
    end
    n_cmp++;
  endtask

  task automatic test_read_write_both();
    drive(1, 1, 8'h60, 8'h3C, 0, 0, 8'h00, 8'h00);
    if ({mem_we, mem_re, rdata_1, mem_wdata} !== {2'b10, 8'h00, 8'h3C}) begin
      n_bad++; $display("FAIL rw_store got %b/%h/%h want 10/00/3c", {mem_we, mem_re}, rdata_1, mem_wdata);
    end
    n_cmp++;
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00);
    if (rdata_2 !== 8'h3C) begin
      n_bad++; $display("FAIL rw_readback got %h want 3c", rdata_2);
    end
    n_cmp++;
  endtask

  initial begin
    reset = 1'b1;
    memread_1 = 0; memwrite_1 = 0; addr_1 = '0; wdata_1 = '0;
    memread_2 = 0; memwrite_2 = 0; addr_2 = '0; wdata_2 = '0;
    test_reset();
    test_single_store();
    test_single_load2();
    test_conflict_loads();
    test_ordering();
    test_reset_in_second();
    test_read_write_both();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
